uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the number of data bits per frame (legal range 5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning the os_tick pulses per bit period (power of two, >= 8).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port rx_line, input, 1, the asynchronous serial input, idle high.
REQ-006 SHALL have port os_tick, input, 1, a one-clk-wide oversampling strobe at OVERSAMPLE x baud.
REQ-007 SHALL have port data_out, output, DATA_BITS, the last received data word; it holds until the next rx_valid.
REQ-008 SHALL have port rx_valid, output, 1, a one-clk pulse marking data_out, frame_err and parity_err valid.
REQ-009 SHALL have port frame_err, output, 1, asserted with rx_valid when the sampled stop bit is 0.
REQ-010 SHALL have port parity_err, output, 1, asserted with rx_valid on a parity mismatch; constant 0 without UART_RX_PARITY_EN.
REQ-011 SHALL have port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL pass rx_line through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY (macro only) and STOP, plus a tick counter of width log2(OVERSAMPLE) and a bit counter.
REQ-014 IDLE: on a synchronized falling edge (previous 1, current 0) SHALL go to START and clear the tick counter; a line held low never retriggers.
REQ-015 START: counting os_tick, at count OVERSAMPLE/2-1 SHALL go to DATA with counters cleared if the line is 0, else return to IDLE (glitch reject).
REQ-016 DATA: SHALL sample at each count OVERSAMPLE-1 (bit centre) and shift LSB-first into the shift register.
REQ-017 DATA: after DATA_BITS samples SHALL go to PARITY if the macro is defined, else to STOP.
REQ-018 STOP: at count OVERSAMPLE-1 SHALL sample the stop bit, load data_out from the shift register, pulse rx_valid, set frame_err to NOT(stop bit), and go to IDLE.
REQ-019 rx_valid SHALL assert in the clk cycle after the os_tick that samples the stop bit, and last exactly one cycle.
REQ-020 frame_err and parity_err SHALL be valid only while rx_valid is high and SHALL be 0 otherwise.
REQ-021 Clk cycles without os_tick SHALL NOT advance any counter.
REQ-022 A frame SHALL be delivered even when frame_err is set; a low line after a framing error SHALL wait in IDLE for a high-to-low edge.
REQ-023 Back-to-back frames with no idle gap SHALL be received without loss.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, all counters and the shift register to 0, data_out to 0, rx_valid, frame_err, parity_err and rx_busy to 0, and the synchronizer to 1.
REQ-025 Reset mid-frame SHALL discard the partial frame with no rx_valid; the first falling edge after release starts a new frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, when defined, SHALL add the PARITY state: sample one even-parity bit at the bit centre, then go to STOP; parity_err = XOR(data bits, parity bit).
REQ-027 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent and parity_err SHALL be tied to 0.

Structure
REQ-028 Shared package uart_pkg SHALL hold the rx state enumeration, the default OVERSAMPLE and DATA_BITS constants, and the mid-bit index constant.
REQ-029 The synchronizer and edge detector SHALL be sub-module uart_rx_sync (inputs clk, rst_n, async_in; outputs sync_out, fall_edge).

Verification (50 MHz clk, os_tick every clk, 16 clk per bit)
REQ-030 Frame 0xA5 (LSB first 1,0,1,0,0,1,0,1) -> one rx_valid pulse, data_out=0xA5, frame_err=0.
REQ-031 rx_line low for 4 clk then high -> no rx_valid, rx_busy returns 0 within 8 clk.
REQ-032 Frame 0x3C with stop bit 0 -> rx_valid, data_out=0x3C, frame_err=1; line high, then frame 0x5A -> data_out=0x5A, frame_err=0.
REQ-033 rst_n pulsed low after the 3rd data bit -> all outputs 0, no rx_valid; next frame 0x81 -> data_out=0x81.
REQ-034 Back-to-back frames 0x00 then 0xFF with no gap -> two rx_valid pulses 160 clk apart, correct data each.
REQ-035 With UART_RX_PARITY_EN: 0xA5 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Optional parity support is enabled with `define UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS  = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Tick index at which a start bit is re-checked (half a bit after the edge).
  function automatic int unsigned mid_bit_idx(input int unsigned oversample);
    return oversample / 2 - 1;
  endfunction

  localparam int unsigned MID_BIT_IDX = mid_bit_idx(DEFAULT_OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd3
`endif
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector
// on the synchronized signal. All flops reset to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall_edge
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out  = sync_q;
  assign fall_edge = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, one stop bit.
// `define UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_line,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(mid_bit_idx(OVERSAMPLE));
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_sync;
  logic fall_edge;

  rx_state_e             state_q, state_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_out_d;
  logic                  rx_valid_d;
  logic                  frame_err_d;
  logic                  rx_busy_d;
  logic                  bit_end;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_d;
  logic                  parity_err_d;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (rx_line),
    .sync_out  (rx_sync),
    .fall_edge (fall_edge)
  );

  assign bit_end = os_tick && (tick_q == LAST_TICK);

  // State, counters and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state; the tick counter wraps naturally at OVERSAMPLE.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (os_tick) tick_d = tick_q + TICK_W'(1);
        if (bit_end) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (os_tick) tick_d = tick_q + TICK_W'(1);
        if (bit_end) begin
          par_d   = rx_sync;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (os_tick) tick_d = tick_q + TICK_W'(1);
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; error flags are only ever high alongside rx_valid.
  always_comb begin
    data_out_d   = data_out;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    rx_busy_d    = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (state_q == STOP && bit_end) begin
      data_out_d   = shift_q;
      rx_valid_d   = 1'b1;
      frame_err_d  = ~rx_sync;
`ifdef UART_RX_PARITY_EN
      parity_err_d = (^shift_q) ^ par_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      data_out  <= data_out_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      rx_busy   <= rx_busy_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_err_d;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: os_tick every clk, 16 clk per bit.
module tb_uart_rx;

  localparam int unsigned DW      = 8;
  localparam int unsigned BIT_CLK = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          rx_line = 1'b1;
  logic          os_tick = 1'b1;
  logic [DW-1:0] data_out;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcount = 0;
  int stray  = 0;
  int wide   = 0;
  logic prev_valid = 1'b0;
  logic [DW-1:0] cap_data [16];
  logic          cap_fe   [16];
  logic          cap_pe   [16];
  int            cap_cyc  [16];
  int            v0;

  uart_rx #(.DATA_BITS(DW), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_line    (rx_line),
    .os_tick    (os_tick),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every rx_valid pulse and flag errors seen outside of one.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (vcount < 16) begin
        cap_data[vcount] = data_out;
        cap_fe[vcount]   = frame_err;
        cap_pe[vcount]   = parity_err;
        cap_cyc[vcount]  = cyc;
      end
      vcount++;
    end else if (frame_err || parity_err) begin
      stray++;
    end
    if (rx_valid && prev_valid) wide++;
    prev_valid = rx_valid;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [DW-1:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_rx_busy", 32'(rx_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clean frame 0xA5
    v0 = vcount;
    send_frame(8'hA5, 1'b1);
    #2;
    chk("a5_count", 32'(vcount), 32'(v0 + 1));
    chk("a5_data", 32'(cap_data[v0]), 32'hA5);
    chk("a5_frame_err", 32'(cap_fe[v0]), 32'h0);
    chk("a5_parity_err", 32'(cap_pe[v0]), 32'h0);
    send_bit(1'b1);

    // Short glitch is rejected
    v0 = vcount;
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("glitch_busy_high", 32'(rx_busy), 32'h1);
    rx_line = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    chk("glitch_busy_low", 32'(rx_busy), 32'h0);
    send_bit(1'b1);
    chk("glitch_no_valid", 32'(vcount), 32'(v0));

    // Framing error then recovery
    v0 = vcount;
    send_frame(8'h3C, 1'b0);
    #2;
    chk("fe_count", 32'(vcount), 32'(v0 + 1));
    chk("fe_data", 32'(cap_data[v0]), 32'h3C);
    chk("fe_frame_err", 32'(cap_fe[v0]), 32'h1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("fe_no_retrigger", 32'(vcount), 32'(v0 + 1));
    send_frame(8'h5A, 1'b1);
    #2;
    chk("rec_count", 32'(vcount), 32'(v0 + 2));
    chk("rec_data", 32'(cap_data[v0 + 1]), 32'h5A);
    chk("rec_frame_err", 32'(cap_fe[v0 + 1]), 32'h0);
    send_bit(1'b1);

    // Reset after the third data bit of 0x81
    v0 = vcount;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("mid_busy_before", 32'(rx_busy), 32'h1);
    rx_line = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("mid_data_out", 32'(data_out), 32'h0);
    chk("mid_rx_valid", 32'(rx_valid), 32'h0);
    chk("mid_frame_err", 32'(frame_err), 32'h0);
    chk("mid_parity_err", 32'(parity_err), 32'h0);
    chk("mid_rx_busy", 32'(rx_busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    chk("mid_no_valid", 32'(vcount), 32'(v0));
    send_frame(8'h81, 1'b1);
    #2;
    chk("post_rst_count", 32'(vcount), 32'(v0 + 1));
    chk("post_rst_data", 32'(cap_data[v0]), 32'h81);
    send_bit(1'b1);

    // Back-to-back 0x00 then 0xFF, no idle gap
    v0 = vcount;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    #2;
    chk("b2b_count", 32'(vcount), 32'(v0 + 2));
    chk("b2b_data0", 32'(cap_data[v0]), 32'h00);
    chk("b2b_data1", 32'(cap_data[v0 + 1]), 32'hFF);
    chk("b2b_spacing", 32'(cap_cyc[v0 + 1] - cap_cyc[v0]), 32'd160);
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0xA5 has four ones, so parity bit 1 is an error
    v0 = vcount;
    send_frame_par(8'hA5, 1'b1);
    #2;
    chk("par1_count", 32'(vcount), 32'(v0 + 1));
    chk("par1_data", 32'(cap_data[v0]), 32'hA5);
    chk("par1_parity_err", 32'(cap_pe[v0]), 32'h1);
    send_bit(1'b1);
    send_frame_par(8'hA5, 1'b0);
    #2;
    chk("par0_count", 32'(vcount), 32'(v0 + 2));
    chk("par0_parity_err", 32'(cap_pe[v0 + 1]), 32'h0);
    send_bit(1'b1);
`endif

    chk("stray_err_flags", 32'(stray), 32'h0);
    chk("valid_one_cycle", 32'(wide), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
